// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states,
// opcodes, instruction classes and ALU select/operation codes.
package ctrl_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_ADDI = 3'd2,
    CLS_LD   = 3'd3,
    CLS_SD   = 3'd4,
    CLS_BEQ  = 3'd5
  } cls_t;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;
  localparam logic [1:0] ALU_OP_ADDI = 2'b11;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier.
// Ports: opcode (IR[6:0]) -> cls (instruction class), illegal.
module mc_opdecode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      (opcode == OP_R):    cls = CLS_R;
      (opcode == OP_ADDI): cls = CLS_ADDI;
      (opcode == OP_LD):   cls = CLS_LD;
      (opcode == OP_SD):   cls = CLS_SD;
      (opcode == OP_BEQ):  cls = CLS_BEQ;
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// FSM sequencer for the multicycle RISC-V datapath: drives all datapath
// enables/selects and the shared-memory req/ack handshake with timeout.
// Ports: clk_i, rst_i (async, active-low), start_i, opcode_i, mem_ack_i in;
// mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, branch_o, alu_src_a_o,
// alu_src_b_o, alu_op_o, reg_we_o, memtoreg_o, busy_o, err_o out.
// Macro CTRL_PERF_EN adds cyc_cnt_o, instret_o, memwait_o counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [6:0] opcode_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       branch_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       reg_we_o,
  output logic       memtoreg_o,
  output logic       busy_o,
  output logic       err_o
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [CNT_W-1:0] memwait_o
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]    state;
  logic [2:0]    nxt;
  cls_t          cls;
  cls_t          dec_cls;
  logic          dec_ill;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          in_req;
  logic          ack;
  logic          bnd;
  logic [2:0]    bnd_st;

  mc_opdecode u_dec (
    .opcode  (opcode_i),
    .cls     (dec_cls),
    .illegal (dec_ill)
  );

  assign in_req  = (state == S_FETCH) || (state == S_MEM);
  // ack only means something while a request is outstanding
  assign ack     = in_req && mem_ack_i;
  assign tmo_hit = (tmo_cnt == TW'(MEM_TIMEOUT - 1));
  assign bnd_st  = start_i ? S_FETCH : S_IDLE;

  // Instruction retires on the edge that ends this cycle
  assign bnd = ((state == S_EXEC) && (cls == CLS_BEQ))
            || ((state == S_MEM) && ack && (cls == CLS_SD))
            || (state == S_WB);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start_i) nxt = S_FETCH;
      S_FETCH: begin
        if (ack)          nxt = S_DECODE;
        else if (tmo_hit) nxt = S_ERROR;
      end
      S_DECODE: nxt = dec_ill ? S_ERROR : S_EXEC;
      S_EXEC: begin
        if (cls == CLS_BEQ)
          nxt = bnd_st;
        else if ((cls == CLS_LD) || (cls == CLS_SD))
          nxt = S_MEM;
        else
          nxt = S_WB;
      end
      S_MEM: begin
        if (ack)          nxt = (cls == CLS_LD) ? S_WB : bnd_st;
        else if (tmo_hit) nxt = S_ERROR;
      end
      S_WB:     nxt = bnd_st;
      S_ERROR:  nxt = S_ERROR;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      cls     <= CLS_NONE;
      tmo_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE)
        cls <= dec_cls;
      // Cleared outside requests and on ack, so every
      // FETCH/MEM entry starts from zero
      if (in_req && !ack)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    iord_o      = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    branch_o    = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = ALU_SRC_B_RS2;
    alu_op_o    = ALU_OP_ADD;
    reg_we_o    = 1'b0;
    memtoreg_o  = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        ir_we_o     = mem_ack_i;
        pc_we_o     = mem_ack_i;
        alu_src_b_o = ALU_SRC_B_FOUR;
        alu_op_o    = ALU_OP_ADD;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        unique case (cls)
          CLS_R: begin
            alu_src_b_o = ALU_SRC_B_RS2;
            alu_op_o    = ALU_OP_FUNC;
          end
          CLS_ADDI: begin
            alu_src_b_o = ALU_SRC_B_IMM;
            alu_op_o    = ALU_OP_ADDI;
          end
          CLS_LD, CLS_SD: begin
            alu_src_b_o = ALU_SRC_B_IMM;
            alu_op_o    = ALU_OP_ADD;
          end
          CLS_BEQ: begin
            alu_src_b_o = ALU_SRC_B_RS2;
            alu_op_o    = ALU_OP_SUB;
            branch_o    = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = (cls == CLS_SD);
      end
      S_WB: begin
        reg_we_o   = 1'b1;
        memtoreg_o = (cls == CLS_LD);
      end
      default: ;
    endcase
  end

  assign busy_o = (state != S_IDLE) && (state != S_ERROR);
  assign err_o  = (state == S_ERROR);

`ifdef CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_cnt_o <= '0;
      instret_o <= '0;
      memwait_o <= '0;
    end else begin
      if (busy_o)
        cyc_cnt_o <= cyc_cnt_o + 1'b1;
      if (bnd)
        instret_o <= instret_o + 1'b1;
      if (mem_req_o && !mem_ack_i)
        memwait_o <= memwait_o + 1'b1;
    end
  end
`else
  logic unused_bnd;
  assign unused_bnd = bnd;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: steps instructions
// cycle by cycle and compares the packed control vector per state.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we, branch;
  logic       src_a, reg_we, m2r, busy, err;
  logic [1:0] src_b, alu_op;
`ifdef CTRL_PERF_EN
  logic [31:0] cyc_cnt, instret, memwait;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .opcode_i    (opcode),
    .mem_ack_i   (mem_ack),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .iord_o      (iord),
    .ir_we_o     (ir_we),
    .pc_we_o     (pc_we),
    .branch_o    (branch),
    .alu_src_a_o (src_a),
    .alu_src_b_o (src_b),
    .alu_op_o    (alu_op),
    .reg_we_o    (reg_we),
    .memtoreg_o  (m2r),
    .busy_o      (busy),
    .err_o       (err)
`ifdef CTRL_PERF_EN
    ,
    .cyc_cnt_o   (cyc_cnt),
    .instret_o   (instret),
    .memwait_o   (memwait)
`endif
  );

  // {req,we,iord,irwe,pcwe,br,srca,srcb[2],aluop[2],regwe,m2r,busy,err}
  logic [14:0] ctl;
  assign ctl = {mem_req, mem_we, iord, ir_we, pc_we, branch, src_a,
                src_b, alu_op, reg_we, m2r, busy, err};

  localparam logic [14:0] V_IDLE = 15'b0_0_0_0_0_0_0_00_00_0_0_0_0;
  localparam logic [14:0] V_FW   = 15'b1_0_0_0_0_0_0_01_00_0_0_1_0;
  localparam logic [14:0] V_FA   = 15'b1_0_0_1_1_0_0_01_00_0_0_1_0;
  localparam logic [14:0] V_DEC  = 15'b0_0_0_0_0_0_0_00_00_0_0_1_0;
  localparam logic [14:0] V_EXR  = 15'b0_0_0_0_0_0_1_00_10_0_0_1_0;
  localparam logic [14:0] V_EXI  = 15'b0_0_0_0_0_0_1_10_11_0_0_1_0;
  localparam logic [14:0] V_EXM  = 15'b0_0_0_0_0_0_1_10_00_0_0_1_0;
  localparam logic [14:0] V_EXB  = 15'b0_0_0_0_0_1_1_00_01_0_0_1_0;
  localparam logic [14:0] V_MEML = 15'b1_0_1_0_0_0_0_00_00_0_0_1_0;
  localparam logic [14:0] V_MEMS = 15'b1_1_1_0_0_0_0_00_00_0_0_1_0;
  localparam logic [14:0] V_WBR  = 15'b0_0_0_0_0_0_0_00_00_1_0_1_0;
  localparam logic [14:0] V_WBL  = 15'b0_0_0_0_0_0_0_00_00_1_1_1_0;
  localparam logic [14:0] V_ERR  = 15'b0_0_0_0_0_0_0_00_00_0_0_0_1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: apply ack, check, advance a cycle
  task automatic cyc(input string tag, input logic a,
                     input logic [14:0] e);
    mem_ack = a;
    #1;
    chk(tag, {17'd0, ctl}, {17'd0, e});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    start = 1'b1;
    @(negedge clk);
    #1 chk("rst_outs", {17'd0, ctl}, {17'd0, V_IDLE});
    @(negedge clk);
    rst = 1'b1;
`ifdef CTRL_PERF_EN
    #1 chk("perf_rst", cyc_cnt | instret | memwait, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
`endif

    // add, zero wait states
    opcode = OP_R;
    cyc("add_idle", 1'b0, V_IDLE);
    cyc("add_f",    1'b1, V_FA);
    cyc("add_d",    1'b0, V_DEC);
    cyc("add_e",    1'b0, V_EXR);
    cyc("add_wb",   1'b0, V_WBR);

    // ld with 3 wait states in fetch and mem
    for (int i = 0; i < 3; i++) cyc("ld_fw", 1'b0, V_FW);
    cyc("ld_fa", 1'b1, V_FA);
    opcode = OP_LD;
    cyc("ld_d", 1'b0, V_DEC);
    cyc("ld_e", 1'b0, V_EXM);
    for (int i = 0; i < 3; i++) cyc("ld_mw", 1'b0, V_MEML);
    cyc("ld_ma", 1'b1, V_MEML);
    cyc("ld_wb", 1'b0, V_WBL);

    // sd then beq
    cyc("sd_f", 1'b1, V_FA);
    opcode = OP_SD;
    cyc("sd_d", 1'b0, V_DEC);
    cyc("sd_e", 1'b0, V_EXM);
    cyc("sd_m", 1'b1, V_MEMS);
    cyc("beq_f", 1'b1, V_FA);
    opcode = OP_BEQ;
    cyc("beq_d", 1'b0, V_DEC);
    cyc("beq_e", 1'b0, V_EXB);

    // addi, start dropped in EXEC
    cyc("addi_f", 1'b1, V_FA);
    opcode = OP_ADDI;
    cyc("addi_d", 1'b0, V_DEC);
    start = 1'b0;
    cyc("addi_e", 1'b0, V_EXI);
    cyc("addi_wb", 1'b0, V_WBR);
`ifdef CTRL_PERF_EN
    #1;
    chk("instret", instret, 32'd5);
    chk("memwait", memwait, 32'd6);
    chk("cyc_cnt", cyc_cnt, 32'd26);
`endif
    cyc("idle1", 1'b1, V_IDLE);
    cyc("idle2", 1'b0, V_IDLE);

    // illegal opcode
    start = 1'b1;
    cyc("ill_idle", 1'b0, V_IDLE);
    cyc("ill_f", 1'b1, V_FA);
    opcode = 7'b1111111;
    cyc("ill_d", 1'b0, V_DEC);
    for (int i = 0; i < 3; i++) cyc("ill_err", 1'b1, V_ERR);
    do_reset();
    cyc("ill_rec", 1'b0, V_IDLE);

    // fetch timeout: 16 request cycles, then ERROR with req dropped
    for (int i = 0; i < 16; i++) cyc("tmo_fw", 1'b0, V_FW);
    cyc("tmo_err", 1'b0, V_ERR);
    cyc("tmo_hold", 1'b0, V_ERR);
    do_reset();

    // async reset mid-MEM
    cyc("ar_idle", 1'b0, V_IDLE);
    cyc("ar_f", 1'b1, V_FA);
    opcode = OP_LD;
    cyc("ar_d", 1'b0, V_DEC);
    cyc("ar_e", 1'b0, V_EXM);
    mem_ack = 1'b0;
    #1 chk("ar_mem", {17'd0, ctl}, {17'd0, V_MEML});
    #2 rst = 1'b0;
    #1 chk("ar_async", {17'd0, ctl}, {17'd0, V_IDLE});
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    cyc("ar_after", 1'b0, V_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
